hc595d_scan_ctrl: RTL and testbench
===================================

// Module: hc595d_scan_ctrl
// PURPOSE
// Source-scan sequencer in front of hc595d_drive for the 32x32 NIRS front end. Walks the enabled
// sources (two wavelengths each), then a dark slot; builds the 128-bit LED pattern for the 595 chain.
// Per slot: hands the pattern to the driver, waits for its finish, waits settle, then handshakes one ADC acquisition.
// Tags each acquisition with source/wavelength and flags frame completion.
// PARAMETERS
// NUM_SRC     32     sources in scan; pattern bit for source s, wavelength w = s*4+w (bits s*4+2, s*4+3 always 0)
// CHAIN_LEN   128    595 chain length in bits; driven constant on hc595d_data_len
// SETTLE_CYC  1000   clk cycles from driver finish to acq_trig (LED/optics settling), >=1
// WR_TMO      15     max cycles to see hc595d_wr_finish fall after hc595d_wr_en rises
// PORTS
// clk              in   1    system clock
// rst_n            in   1    asynchronous reset, active low
// scan_start       in   1    1-cycle pulse; starts a scan when idle, ignored otherwise
// scan_stop        in   1    1-cycle pulse; graceful stop (see BEHAVIOUR)
// scan_cont        in   1    1: repeat frames until stop; 0: single frame; sampled at each frame end
// src_mask         in   32   source enable, bit s = source s; sampled at start and at each frame start
// hc595d_data      out  128  LED pattern to driver, stable while hc595d_wr_en=1 and until finish
// hc595d_data_len  out  8    constant CHAIN_LEN
// hc595d_wr_en     out  1    write request level to driver (driver latches on rising edge)
// hc595d_wr_finish in   1    driver idle/done flag (1 at reset)
// acq_trig         out  1    1-cycle pulse: start one ADC acquisition
// acq_done         in   1    1-cycle pulse from ADC side: acquisition complete
// acq_src          out  5    source index of current slot (31 during dark slot)
// acq_wl           out  1    wavelength of current slot (0 during dark slot)
// acq_dark         out  1    1 during dark slot
// frame_done       out  1    1-cycle pulse after dark-slot acquisition completes
// busy             out  1    1 in any state except IDLE
// err_wr_tmo       out  1    sticky; set on driver timeout, cleared by next accepted scan_start
// BEHAVIOUR
// - Reset: all outputs 0 except hc595d_data_len=CHAIN_LEN; state IDLE; counters 0.
// - States: IDLE, PICK, WR_REQ, WR_WAIT_LO, WR_WAIT_HI, SETTLE, ACQ, ACQ_WAIT, OFF_WR, OFF_WAIT.
// - IDLE: scan_start and src_mask!=0 -> latch mask, clear err_wr_tmo, slot=first enabled source wl0 -> PICK.
//   scan_start with src_mask==0 is ignored (stays IDLE, busy=0).
// - PICK (1 cyc): drive hc595d_data = one-hot bit src*4+wl, or all 0 for dark slot; update acq_src/wl/dark -> WR_REQ.
// - WR_REQ: hc595d_wr_en=1; -> WR_WAIT_LO. wr_en stays 1 until WR_WAIT_HI exits, so the driver sees exactly one rising edge.
// - WR_WAIT_LO: wait hc595d_wr_finish==0 (driver lags ~3 cycles). Count >WR_TMO: set err_wr_tmo,
//   wr_en=0 -> IDLE (pattern left as-is). Finish is never taken as done before this low is seen.
// - WR_WAIT_HI: wait hc595d_wr_finish==1, then wr_en=0; settle counter=0 -> SETTLE (no timeout).
// - SETTLE: count SETTLE_CYC cycles -> ACQ. ACQ: acq_trig=1 for one cycle -> ACQ_WAIT.
// - ACQ_WAIT: on acq_done, advance: wl0->wl1 same src; wl1->next enabled src wl0 (ascending, masked bits skipped);
//   past last enabled src -> dark slot; after dark: frame_done pulse same cycle as leaving ACQ_WAIT.
// - Frame end: scan_cont=1 and no stop pending -> resample src_mask (if 0 -> OFF_WR) -> first slot PICK;
//   otherwise -> OFF_WR.
// - scan_stop: set stop_pend; current slot runs to acq_done, then OFF_WR (skip rest of frame, no frame_done unless
//   the stopped slot was the dark slot). stop in IDLE ignored. stop and start same cycle in IDLE: start wins.
// - OFF_WR/OFF_WAIT: write all-zero pattern (same wr_en/finish protocol, same timeout) -> IDLE; LEDs always off at idle.
// - acq_done outside ACQ_WAIT is ignored; acq_done in the same cycle as acq_trig is not counted.
// - Reset mid-scan: immediate return to reset values; LED chain state is not guaranteed until the next scan.
// - Slot latency: PICK->acq_trig = 1 + driver time + SETTLE_CYC + 1 cycles.
// TESTING
// 1 mask=32'h0000_0005, cont=0, SETTLE_CYC=4, driver model, acq_done 3 cyc after trig -> slots (0,0)(0,1)(2,0)(2,1)dark;
//   data bits 0,1,8,9 then 0; one frame_done; then all-zero write; busy falls.
// 2 start with mask=0 -> no wr_en, busy stays 0; start with mask=32'h8000_0000 -> acq_src=31 wl0/wl1, then dark.
// 3 cont=1, mask=all-ones: two full frames (65 acq_trig each) -> frame_done twice; stop mid-slot (src 7 wl1)
//   -> that slot completes, no frame_done, off write, IDLE.
// 4 driver model holds wr_finish=1 forever -> err_wr_tmo set WR_TMO+1 cycles after wr_en rise, IDLE, wr_en=0;
//   next start clears it.
// 5 spurious acq_done in SETTLE and same cycle as acq_trig -> ignored; slot advances only on later acq_done.
// 6 rst_n low during SETTLE -> all outputs to reset values asynchronously; start after release runs a clean frame.

Source files
------------

// File: rtl/hc595d_scan_ctrl.sv
// Source-scan sequencer for the NIRS front end: walks enabled sources (two wavelengths each) plus a
// dark slot, writes each LED pattern through the 595 driver, settles, then handshakes one ADC acquisition.
module hc595d_scan_ctrl #(
    parameter int NUM_SRC    = 32,
    parameter int CHAIN_LEN  = 128,
    parameter int SETTLE_CYC = 1000,
    parameter int WR_TMO     = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       scan_start_i,
    input  logic                       scan_stop_i,
    input  logic                       scan_cont_i,
    input  logic [NUM_SRC-1:0]         src_mask_i,
    output logic [CHAIN_LEN-1:0]       hc595d_data_o,
    output logic [7:0]                 hc595d_data_len_o,
    output logic                       hc595d_wr_en_o,
    input  logic                       hc595d_wr_finish_i,
    output logic                       acq_trig_o,
    input  logic                       acq_done_i,
    output logic [$clog2(NUM_SRC)-1:0] acq_src_o,
    output logic                       acq_wl_o,
    output logic                       acq_dark_o,
    output logic                       frame_done_o,
    output logic                       busy_o,
    output logic                       err_wr_tmo_o
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(SETTLE_CYC + WR_TMO + 2);
    localparam logic [CW-1:0] TMO_C = CW'(WR_TMO);
    localparam logic [CW-1:0] SET_C = CW'(SETTLE_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, PICK, WR_REQ, WR_WAIT_LO, WR_WAIT_HI, SETTLE, ACQ, ACQ_WAIT, OFF_WR, OFF_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic [SW-1:0]        src_q, src_d;
    logic                 wl_q, wl_d, dark_q, dark_d;
    logic                 stop_q, stop_d, seen_lo_q, seen_lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] data_q, data_d;
    logic                 wr_en_q, wr_en_d, err_q, err_d;
    logic [SW-1:0]        asrc_q, asrc_d;
    logic                 awl_q, awl_d, adark_q, adark_d;

    logic [SW-1:0]        first_src, nxt_src;
    logic                 nxt_vld, goto_off, stop_now;

    // Lowest enabled source in the incoming mask, and next enabled source above the current one.
    always_comb begin
        first_src = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (src_mask_i[i]) first_src = SW'(i);
        nxt_src = '0;
        nxt_vld = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (mask_q[i] && (SW'(i) > src_q)) begin
                nxt_src = SW'(i);
                nxt_vld = 1'b1;
            end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        src_d        = src_q;
        wl_d         = wl_q;
        dark_d       = dark_q;
        stop_d       = stop_q;
        seen_lo_d    = seen_lo_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        wr_en_d      = wr_en_q;
        err_d        = err_q;
        asrc_d       = asrc_q;
        awl_d        = awl_q;
        adark_d      = adark_q;
        frame_done_o = 1'b0;
        goto_off     = 1'b0;
        stop_now     = stop_q | scan_stop_i;

        if (state_q != IDLE && scan_stop_i) stop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (scan_start_i && (|src_mask_i)) begin
                    mask_d  = src_mask_i;
                    err_d   = 1'b0;
                    stop_d  = 1'b0;
                    src_d   = first_src;
                    wl_d    = 1'b0;
                    dark_d  = 1'b0;
                    state_d = PICK;
                end
            end
            PICK: begin
                data_d = '0;
                if (!dark_q) data_d[{src_q, 1'b0, wl_q}] = 1'b1;
                asrc_d  = dark_q ? '1 : src_q;
                awl_d   = dark_q ? 1'b0 : wl_q;
                adark_d = dark_q;
                state_d = WR_REQ;
            end
            WR_REQ: begin
                wr_en_d = 1'b1;
                cnt_d   = '0;
                state_d = WR_WAIT_LO;
            end
            WR_WAIT_LO: begin
                if (!hc595d_wr_finish_i) begin
                    state_d = WR_WAIT_HI;
                end else if (cnt_q >= TMO_C) begin
                    err_d   = 1'b1;
                    wr_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_WAIT_HI: begin
                if (hc595d_wr_finish_i) begin
                    wr_en_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q >= SET_C) state_d = ACQ;
                else                cnt_d   = cnt_q + 1'b1;
            end
            ACQ: state_d = ACQ_WAIT;
            ACQ_WAIT: begin
                if (acq_done_i) begin
                    frame_done_o = dark_q;
                    state_d      = PICK;
                    if (stop_now) begin
                        goto_off = 1'b1;
                    end else if (dark_q) begin
                        if (scan_cont_i && (|src_mask_i)) begin
                            mask_d = src_mask_i;
                            src_d  = first_src;
                            wl_d   = 1'b0;
                            dark_d = 1'b0;
                        end else begin
                            goto_off = 1'b1;
                        end
                    end else if (!wl_q) begin
                        wl_d = 1'b1;
                    end else if (nxt_vld) begin
                        src_d = nxt_src;
                        wl_d  = 1'b0;
                    end else begin
                        dark_d = 1'b1;
                    end
                    if (goto_off) begin
                        data_d  = '0;
                        state_d = OFF_WR;
                    end
                end
            end
            OFF_WR: begin
                wr_en_d   = 1'b1;
                cnt_d     = '0;
                seen_lo_d = 1'b0;
                state_d   = OFF_WAIT;
            end
            OFF_WAIT: begin
                // Same two-phase finish handshake as a slot write, folded into one state.
                if (!seen_lo_q) begin
                    if (!hc595d_wr_finish_i) begin
                        seen_lo_d = 1'b1;
                    end else if (cnt_q >= TMO_C) begin
                        err_d   = 1'b1;
                        wr_en_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (hc595d_wr_finish_i) begin
                    wr_en_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            src_q     <= '0;
            wl_q      <= 1'b0;
            dark_q    <= 1'b0;
            stop_q    <= 1'b0;
            seen_lo_q <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            asrc_q    <= '0;
            awl_q     <= 1'b0;
            adark_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            src_q     <= src_d;
            wl_q      <= wl_d;
            dark_q    <= dark_d;
            stop_q    <= stop_d;
            seen_lo_q <= seen_lo_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            asrc_q    <= asrc_d;
            awl_q     <= awl_d;
            adark_q   <= adark_d;
        end
    end

    assign hc595d_data_o     = data_q;
    assign hc595d_data_len_o = 8'(CHAIN_LEN);
    assign hc595d_wr_en_o    = wr_en_q;
    assign acq_trig_o        = (state_q == ACQ);
    assign acq_src_o         = asrc_q;
    assign acq_wl_o          = awl_q;
    assign acq_dark_o        = adark_q;
    assign busy_o            = (state_q != IDLE);
    assign err_wr_tmo_o      = err_q;
endmodule

// File: tb/tb_hc595d_scan_ctrl.sv
// Directed bench for hc595d_scan_ctrl with a behavioural 595 driver and ADC responder.
module tb_hc595d_scan_ctrl;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         scan_start = 1'b0, scan_stop = 1'b0, scan_cont = 1'b0;
    logic [31:0]  src_mask = '0;
    logic [127:0] data;
    logic [7:0]   data_len;
    logic         wr_en, wr_finish = 1'b1;
    logic         acq_trig, acq_done_auto = 1'b0, man_done = 1'b0;
    logic [4:0]   acq_src;
    logic         acq_wl, acq_dark, frame_done, busy, err;

    logic         hang = 1'b0, adc_auto = 1'b1, wr_prev = 1'b0;
    int           drv_cnt = 0, adc_cnt = 0, wr_cnt = 0, trig_cnt = 0, fd_cnt = 0;
    int           n_chk = 0, n_fail = 0;
    logic [127:0] pat_q[$];
    logic [6:0]   slot_q[$];

    hc595d_scan_ctrl #(.NUM_SRC(32), .CHAIN_LEN(128), .SETTLE_CYC(4), .WR_TMO(15)) dut (
        .clk(clk), .rst_n(rst_n), .scan_start_i(scan_start), .scan_stop_i(scan_stop),
        .scan_cont_i(scan_cont), .src_mask_i(src_mask), .hc595d_data_o(data),
        .hc595d_data_len_o(data_len), .hc595d_wr_en_o(wr_en), .hc595d_wr_finish_i(wr_finish),
        .acq_trig_o(acq_trig), .acq_done_i(acq_done_auto | man_done), .acq_src_o(acq_src),
        .acq_wl_o(acq_wl), .acq_dark_o(acq_dark), .frame_done_o(frame_done), .busy_o(busy),
        .err_wr_tmo_o(err)
    );

    always #5 clk = ~clk;

    // Driver: finish drops 3 cycles after the wr_en rise, stays low 4 cycles.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            drv_cnt = 0; wr_prev = 1'b0; wr_finish = 1'b1;
        end else begin
            if (wr_en && !wr_prev) begin
                drv_cnt = 1; wr_cnt++; pat_q.push_back(data);
            end else if (drv_cnt != 0) begin
                drv_cnt = (drv_cnt == 8) ? 0 : drv_cnt + 1;
            end
            wr_prev   = wr_en;
            wr_finish = hang || !(drv_cnt >= 4 && drv_cnt < 8);
        end
    end

    // ADC: acq_done one cycle wide, a few cycles after the trigger.
    always @(posedge clk) begin
        #1;
        acq_done_auto = 1'b0;
        if (!rst_n) adc_cnt = 0;
        else if (acq_trig && adc_auto) adc_cnt = 1;
        else if (adc_cnt != 0) begin
            adc_cnt++;
            if (adc_cnt == 3) begin acq_done_auto = 1'b1; adc_cnt = 0; end
        end
    end

    always @(negedge clk) begin
        if (acq_trig) begin trig_cnt++; slot_q.push_back({acq_dark, acq_src, acq_wl}); end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_scan(input logic [31:0] m, input logic c);
        @(posedge clk); #1;
        src_mask = m; scan_cont = c; scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        @(negedge clk);
        while (busy && n < max) begin @(negedge clk); n++; end
        chk("busy_fall", busy, 1'b0);
    endtask

    task automatic wait_wr(input logic lvl);
        int n = 0;
        while (wr_en !== lvl && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic chk_slot(input string tag, input int idx, input logic [6:0] exp);
        chk(tag, (idx < slot_q.size()) ? slot_q[idx] : 7'h7f, exp);
    endtask

    task automatic chk_pat(input string tag, input int idx, input logic [127:0] exp);
        chk(tag, (idx < pat_q.size()) ? pat_q[idx] : {128{1'b1}}, exp);
    endtask

    int sb, pb, wb, fb, tb0;
    logic [127:0] one = 128'd1;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, '0);
        chk("rst_len", data_len, 8'd128);
        chk("rst_ctl", {wr_en, acq_trig, busy, err, frame_done, acq_dark, acq_wl}, 7'b0);
        chk("rst_src", acq_src, 5'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: sources 0 and 2, single frame
        sb = slot_q.size(); pb = pat_q.size(); fb = fd_cnt;
        start_scan(32'h0000_0005, 1'b0);
        wait_idle(2000);
        chk("t1_ntrig", slot_q.size() - sb, 5);
        chk_slot("t1_s0", sb + 0, {1'b0, 5'd0, 1'b0});
        chk_slot("t1_s1", sb + 1, {1'b0, 5'd0, 1'b1});
        chk_slot("t1_s2", sb + 2, {1'b0, 5'd2, 1'b0});
        chk_slot("t1_s3", sb + 3, {1'b0, 5'd2, 1'b1});
        chk_slot("t1_dark", sb + 4, {1'b1, 5'd31, 1'b0});
        chk("t1_nwr", pat_q.size() - pb, 6);
        chk_pat("t1_p0", pb + 0, one << 0);
        chk_pat("t1_p1", pb + 1, one << 1);
        chk_pat("t1_p2", pb + 2, one << 8);
        chk_pat("t1_p3", pb + 3, one << 9);
        chk_pat("t1_pd", pb + 4, '0);
        chk_pat("t1_off", pb + 5, '0);
        chk("t1_fd", fd_cnt - fb, 1);
        chk("t1_end", {wr_en, data != 0}, 2'b00);

        // 2: empty mask ignored, then source 31 only
        wb = wr_cnt;
        start_scan(32'h0, 1'b0);
        repeat (10) @(negedge clk);
        chk("t2_busy0", busy, 1'b0);
        chk("t2_nowr", wr_cnt - wb, 0);
        sb = slot_q.size(); pb = pat_q.size(); fb = fd_cnt;
        start_scan(32'h8000_0000, 1'b0);
        wait_idle(2000);
        chk("t2_ntrig", slot_q.size() - sb, 3);
        chk_slot("t2_s0", sb + 0, {1'b0, 5'd31, 1'b0});
        chk_slot("t2_s1", sb + 1, {1'b0, 5'd31, 1'b1});
        chk_slot("t2_dark", sb + 2, {1'b1, 5'd31, 1'b0});
        chk_pat("t2_p0", pb + 0, one << 124);
        chk_pat("t2_p1", pb + 1, one << 125);
        chk_pat("t2_pd", pb + 2, '0);
        chk("t2_fd", fd_cnt - fb, 1);

        // 3: continuous, all sources; stop during the 16th slot of the third frame
        sb = slot_q.size(); pb = pat_q.size(); fb = fd_cnt; tb0 = trig_cnt;
        start_scan(32'hFFFF_FFFF, 1'b1);
        for (int n = 0; n < 20000 && trig_cnt - tb0 < 146; n++) @(negedge clk);
        @(posedge clk); #1 scan_stop = 1'b1;
        @(posedge clk); #1 scan_stop = 1'b0;
        wait_idle(2000);
        scan_cont = 1'b0;
        chk("t3_ntrig", trig_cnt - tb0, 146);
        chk("t3_fd", fd_cnt - fb, 2);
        chk_slot("t3_dark1", sb + 64, {1'b1, 5'd31, 1'b0});
        chk_slot("t3_f2s0", sb + 65, {1'b0, 5'd0, 1'b0});
        chk_slot("t3_dark2", sb + 129, {1'b1, 5'd31, 1'b0});
        chk_slot("t3_last", sb + 145, {1'b0, 5'd7, 1'b1});
        chk("t3_nwr", pat_q.size() - pb, 147);
        chk_pat("t3_pstop", pb + 145, one << 29);
        chk_pat("t3_off", pb + 146, '0);

        // 4: driver never drops finish
        hang = 1'b1;
        start_scan(32'h1, 1'b0);
        wait_wr(1'b1);
        repeat (15) @(negedge clk);
        chk("t4_pre", {err, wr_en}, 2'b01);
        @(negedge clk);
        chk("t4_tmo", {err, wr_en, busy}, 3'b100);
        hang = 1'b0;
        fb = fd_cnt;
        start_scan(32'h1, 1'b0);
        @(negedge clk);
        chk("t4_clr", err, 1'b0);
        wait_idle(2000);
        chk("t4_fd", fd_cnt - fb, 1);

        // 5: stray acq_done in SETTLE and alongside acq_trig
        adc_auto = 1'b0; tb0 = trig_cnt; wb = wr_cnt; fb = fd_cnt;
        start_scan(32'h1, 1'b0);
        @(negedge clk);
        wait_wr(1'b1);
        wait_wr(1'b0);
        man_done = 1'b1; @(negedge clk); man_done = 1'b0;
        for (int n = 0; n < 50 && !acq_trig; n++) @(negedge clk);
        man_done = 1'b1; @(negedge clk); man_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_hold", {trig_cnt - tb0, wr_cnt - wb, 1'b0 + acq_wl}, {32'd1, 32'd1, 1'b0});
        adc_auto = 1'b1;
        man_done = 1'b1; @(negedge clk); man_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_adv", {wr_cnt - wb, 1'b0 + acq_wl}, {32'd2, 1'b1});
        wait_idle(2000);
        chk("t5_ntrig", trig_cnt - tb0, 3);
        chk("t5_fd", fd_cnt - fb, 1);

        // 6: asynchronous reset while settling
        start_scan(32'h1, 1'b0);
        @(negedge clk);
        wait_wr(1'b1);
        wait_wr(1'b0);
        chk("t6_pre", data, one);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst", {data != 0, wr_en, busy, acq_trig, err, acq_dark, acq_wl}, 7'b0);
        chk("t6_rsrc", acq_src, 5'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tb0 = trig_cnt; fb = fd_cnt;
        start_scan(32'h1, 1'b0);
        wait_idle(2000);
        chk("t6_ntrig", trig_cnt - tb0, 3);
        chk("t6_fd", fd_cnt - fb, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
